mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single main-memory port between the instruction cache and the data cache.
// - Arbitrates between the two caches and sequences one block transfer at a time.
// - Returns read data and busywait to the requester that won the grant.
// - Sits between icache/dcache and data_memory inside cpu-level integration.
// PARAMETERS
// - ADDR_W   default 6    block address width (shared by both caches)
// - BLOCK_W  default 128  block data width, in bits
// PORTS
// - CLK          in   1        system clock; all state changes on posedge
// - RESET        in   1        synchronous, active-low reset
// - d_read       in   1        dcache block read request
// - d_write      in   1        dcache block write request
// - d_address    in   ADDR_W   dcache block address
// - d_writedata  in   BLOCK_W  dcache write block
// - d_readdata   out  BLOCK_W  registered read block returned to dcache
// - d_busywait   out  1        stall to dcache
// - i_read       in   1        icache block read request (read-only)
// - i_address    in   ADDR_W   icache block address
// - i_readdata   out  BLOCK_W  registered read block returned to icache
// - i_busywait   out  1        stall to icache
// - m_read       out  1        read strobe to main memory
// - m_write      out  1        write strobe to main memory
// - m_address    out  ADDR_W   address to main memory
// - m_writedata  out  BLOCK_W  write block to main memory
// - m_readdata   in   BLOCK_W  read block from main memory
// - m_busywait   in   1        main memory busy
// BEHAVIOUR
// - FSM states: IDLE, D_ACC, I_ACC, D_REL, I_REL; all state registered.
// - Reset (RESET==0 at posedge):
//   - state=IDLE, first-cycle flag=0, rr pointer=D;
//   - d_readdata=0, i_readdata=0;
//   - m_read=0, m_write=0, m_address=0, m_writedata=0.
// - IDLE:
//   - Both requests are sampled; a winner is chosen and latched.
//   - Winner dcache -> D_ACC; winner icache -> I_ACC. One cycle arbitration latency.
// - D_ACC / I_ACC:
//   - m_* are driven from the granted requester's registered inputs (address/data latched on grant).
//   - Latched values stay stable for the whole access.
//   - m_read=1 for a read; for dcache, m_write=d_write.
//   - If d_read and d_write are both 1, the access is a write.
//   - Completion: m_busywait==0 on any ACC cycle other than the first.
//   - On completion, m_readdata is captured into the granted *_readdata.
//   - Next state is the matching REL state.
// - D_REL / I_REL:
//   - m_read=m_write=0.
//   - The granted *_busywait is 0 for exactly this one cycle.
//   - Next state is IDLE.
// - busywait rule:
//   - d_busywait = (d_read|d_write) & (state!=D_REL).
//   - i_busywait = i_read & (state!=I_REL).
//   - The loser stays stalled for the full duration of the winner's access.
// - Request withdrawn mid-access: the access still completes.
//   - The captured data is dropped silently.
//   - No abort is possible on the memory side.
// - A request still held after REL is arbitrated again as a new access from IDLE.
// - *_readdata holds its value until that requester's next completed read; writes leave d_readdata unchanged.
// - Worst-case latency per access = 1 (arbitration) + memory latency + 1 (release) cycles.
// CONFIGURATION
// - ROUND_ROBIN_EN defined:
//   - When both request in IDLE, the grant goes to the requester not served last (rr pointer).
//   - rr pointer updates on entry to REL.
//   - The pointer is ignored when only one requester is active.
// - ROUND_ROBIN_EN undefined:
//   - Fixed priority; dcache always wins a tie.
//   - icache may starve under continuous dcache traffic.
// TESTING
// - Reset: RESET=0 for 2 cycles mid-D_ACC -> next posedge state=IDLE, m_read=m_write=0, readdata=0.
// - Single read: i_read=1, i_address=6'h05, memory returns 128'hA5.. after 5 busy cycles.
//   - Expect i_readdata=128'hA5.., one i_busywait low cycle, total 7 cycles.
// - Single write: d_write=1, d_address=6'h3F, d_writedata=128'h1234.
//   - Expect m_write=1, m_address=3F, m_writedata=1234 held stable until m_busywait drops.
// - Tie, fixed priority: d_read and i_read asserted same cycle.
//   - Expect dcache served first, then icache; i_busywait high throughout dcache access.
// - Tie, ROUND_ROBIN_EN: three back-to-back ties after reset -> grant order D, I, D.
// - Withdrawal: d_read dropped during D_ACC -> access completes, then IDLE; m_read low in D_REL.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side block-transfer signals of mem_arbiter.
// slave: the arbiter's view; master: the caches/memory environment.
interface mem_arbiter_if #(
    parameter int ADDR_W  = 6,
    parameter int BLOCK_W = 128
);
    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_address;
    logic [BLOCK_W-1:0] d_writedata;
    logic [BLOCK_W-1:0] d_readdata;
    logic               d_busywait;

    logic               i_read;
    logic [ADDR_W-1:0]  i_address;
    logic [BLOCK_W-1:0] i_readdata;
    logic               i_busywait;

    logic               m_read;
    logic               m_write;
    logic [ADDR_W-1:0]  m_address;
    logic [BLOCK_W-1:0] m_writedata;
    logic [BLOCK_W-1:0] m_readdata;
    logic               m_busywait;

    modport slave (
        input  d_read, d_write, d_address, d_writedata,
        output d_readdata, d_busywait,
        input  i_read, i_address,
        output i_readdata, i_busywait,
        output m_read, m_write, m_address, m_writedata,
        input  m_readdata, m_busywait
    );

    modport master (
        output d_read, d_write, d_address, d_writedata,
        input  d_readdata, d_busywait,
        output i_read, i_address,
        input  i_readdata, i_busywait,
        input  m_read, m_write, m_address, m_writedata,
        output m_readdata, m_busywait
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one main-memory block port between icache and dcache, one transfer at a time.
// Define ROUND_ROBIN_EN for round-robin tie breaking; otherwise dcache wins every tie.
module mem_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int BLOCK_W = 128
) (
    input  logic         CLK,
    input  logic         RESET,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, D_ACC, I_ACC, D_REL, I_REL} state_t;

    state_t             state_reg, state_next;
    logic               first_reg, first_next;
    logic               wr_reg, wr_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [BLOCK_W-1:0] wdata_reg, wdata_next;
    logic [BLOCK_W-1:0] d_rdata_reg, d_rdata_next;
    logic [BLOCK_W-1:0] i_rdata_reg, i_rdata_next;
    logic               d_req, i_req, grant_d, done;

    assign d_req = bus.d_read | bus.d_write;
    assign i_req = bus.i_read;
    // Memory may not have raised busywait yet on the first ACC cycle, so it is ignored there.
    assign done  = ~first_reg & ~bus.m_busywait;

`ifdef ROUND_ROBIN_EN
    logic rr_reg, rr_next;  // 1: icache wins the next tie

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rr_reg <= 1'b0;
        end else begin
            rr_reg <= rr_next;
        end
    end

    always_comb begin
        rr_next = rr_reg;
        if (state_next == D_REL) begin
            rr_next = 1'b1;
        end else if (state_next == I_REL) begin
            rr_next = 1'b0;
        end
    end

    assign grant_d = d_req & (~i_req | ~rr_reg);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg   <= IDLE;
            first_reg   <= 1'b0;
            wr_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            d_rdata_reg <= '0;
            i_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            first_reg   <= first_next;
            wr_reg      <= wr_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            d_rdata_reg <= d_rdata_next;
            i_rdata_reg <= i_rdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        first_next   = 1'b0;
        wr_next      = wr_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        d_rdata_next = d_rdata_reg;
        i_rdata_next = i_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next = D_ACC;
                    first_next = 1'b1;
                    wr_next    = bus.d_write;
                    addr_next  = bus.d_address;
                    wdata_next = bus.d_writedata;
                end else if (i_req) begin
                    state_next = I_ACC;
                    first_next = 1'b1;
                    wr_next    = 1'b0;
                    addr_next  = bus.i_address;
                end
            end
            D_ACC: begin
                if (done) begin
                    state_next = D_REL;
                    if (!wr_reg) begin
                        d_rdata_next = bus.m_readdata;
                    end
                end
            end
            I_ACC: begin
                if (done) begin
                    state_next   = I_REL;
                    i_rdata_next = bus.m_readdata;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        case (state_reg)
            D_ACC: begin
                bus.m_read  = ~wr_reg;
                bus.m_write = wr_reg;
            end
            I_ACC:   bus.m_read = 1'b1;
            default: ;
        endcase
        bus.m_address   = addr_reg;
        bus.m_writedata = wdata_reg;
        bus.d_readdata  = d_rdata_reg;
        bus.i_readdata  = i_rdata_reg;
        bus.d_busywait  = d_req & (state_reg != D_REL);
        bus.i_busywait  = i_req & (state_reg != I_REL);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural block memory plus an expected-transaction queue.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W  = 6;
    localparam int BLOCK_W = 128;

    typedef struct {
        bit                 is_d;
        bit                 is_wr;
        logic [ADDR_W-1:0]  addr;
        logic [BLOCK_W-1:0] data;
    } txn_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();
    mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rr_d  = 1'b1;  // next tie goes to dcache (round-robin build)

    // Unwritten blocks read back a fixed pattern; block 5 holds all-A5.
    function automatic logic [BLOCK_W-1:0] pat(input int a);
        logic [31:0] w;
        if (a == 5) return {16{8'hA5}};
        w = 32'hC0DE_0000 ^ (32'(a) * 32'h0101_0101);
        return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(a) + 32'h1};
    endfunction

    // Memory: a strobed access lasts mem_lat cycles, busywait low on the last one.
    logic [BLOCK_W-1:0] wmem [0:63];
    bit                 written [0:63];
    int                 mem_cnt = 0;
    int                 mem_lat = 5;

    assign bus.m_busywait = (bus.m_read | bus.m_write) && (mem_cnt < mem_lat - 1);
    assign bus.m_readdata = written[bus.m_address] ? wmem[bus.m_address] : pat(int'(bus.m_address));

    always @(posedge CLK) begin
        if (bus.m_read | bus.m_write) begin
            mem_cnt <= mem_cnt + 1;
            if (bus.m_write && !bus.m_busywait) begin
                wmem[bus.m_address]    <= bus.m_writedata;
                written[bus.m_address] <= 1'b1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Counts negedges until a requester sees its one-cycle busywait release; -1 on timeout.
    task automatic wait_release(output int cycles, output bit got_d);
        bit found;
        found  = 1'b0;
        cycles = -1;
        got_d  = 1'b0;
        for (int n = 1; n <= 100 && !found; n++) begin
            @(negedge CLK);
            if ((bus.d_read | bus.d_write) && !bus.d_busywait) begin
                found = 1'b1; cycles = n; got_d = 1'b1;
            end else if (bus.i_read && !bus.i_busywait) begin
                found = 1'b1; cycles = n; got_d = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        RESET           = 1'b0;
        bus.d_read      = 1'b0;
        bus.d_write     = 1'b0;
        bus.d_address   = '0;
        bus.d_writedata = '0;
        bus.i_read      = 1'b0;
        bus.i_address   = '0;
        repeat (2) @(negedge CLK);
        n_cmp++; if ({bus.m_read, bus.m_write} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes: got %b want 00", {bus.m_read, bus.m_write}); end
        n_cmp++; if (bus.m_address !== '0) begin n_bad++; $display("FAIL rst_m_address: got %h want 0", bus.m_address); end
        n_cmp++; if (bus.m_writedata !== '0) begin n_bad++; $display("FAIL rst_m_writedata: got %h want 0", bus.m_writedata); end
        n_cmp++; if (bus.d_readdata !== '0) begin n_bad++; $display("FAIL rst_d_readdata: got %h want 0", bus.d_readdata); end
        n_cmp++; if (bus.i_readdata !== '0) begin n_bad++; $display("FAIL rst_i_readdata: got %h want 0", bus.i_readdata); end
        n_cmp++; if ({bus.d_busywait, bus.i_busywait} !== 2'b00) begin n_bad++; $display("FAIL rst_busywait: got %b want 00", {bus.d_busywait, bus.i_busywait}); end
        RESET = 1'b1;
        rr_d  = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_read();
        txn_t e; int cyc; bit got_d;
        mem_lat = 5;
        e.is_d = 1'b0; e.is_wr = 1'b0; e.addr = 6'h05; e.data = {16{8'hA5}};
        exp_q.push_back(e);
        bus.i_address = 6'h05;
        bus.i_read    = 1'b1;
        wait_release(cyc, got_d);
        e = exp_q.pop_front();
        $display("txn I read addr=%h latency=%0d data=%h", e.addr, cyc, bus.i_readdata);
        // 1 arbitration + 5 access cycles, released on the 7th cycle
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL rd_latency: got %0d want 6", cyc); end
        n_cmp++; if (got_d !== e.is_d) begin n_bad++; $display("FAIL rd_grant: got d=%0d want d=%0d", got_d, e.is_d); end
        n_cmp++; if (bus.i_readdata !== e.data) begin n_bad++; $display("FAIL rd_data: got %h want %h", bus.i_readdata, e.data); end
        rr_d = 1'b1;
        @(negedge CLK);
        n_cmp++; if (bus.i_busywait !== 1'b1) begin n_bad++; $display("FAIL rd_bw_one_cycle: got %b want 1", bus.i_busywait); end
        bus.i_read = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single_write();
        txn_t e; int n, strobes; bit found;
        logic [ADDR_W-1:0] a; logic [BLOCK_W-1:0] wd, rd_before;
        mem_lat = 5;
        for (int k = 0; k < 2; k++) begin
            a  = (k == 0) ? 6'h3F : 6'h2A;
            wd = (k == 0) ? 128'h1234 : ~pat(42);
            rd_before = bus.d_readdata;
            e.is_d = 1'b1; e.is_wr = 1'b1; e.addr = a; e.data = wd;
            exp_q.push_back(e);
            bus.d_address   = a;
            bus.d_writedata = wd;
            bus.d_write     = 1'b1;
            bus.d_read      = (k == 1);
            n = 0; strobes = 0; found = 1'b0;
            while (!found && n < 100) begin
                @(negedge CLK);
                n++;
                if (n == 2) begin
                    bus.d_address   = ~a;
                    bus.d_writedata = ~wd;
                end
                if (bus.m_write) begin
                    strobes++;
                    n_cmp++; if (bus.m_address !== a) begin n_bad++; $display("FAIL wr_m_address: got %h want %h", bus.m_address, a); end
                    n_cmp++; if (bus.m_writedata !== wd) begin n_bad++; $display("FAIL wr_m_writedata: got %h want %h", bus.m_writedata, wd); end
                    n_cmp++; if (bus.m_read !== 1'b0) begin n_bad++; $display("FAIL wr_m_read: got %b want 0", bus.m_read); end
                end
                if (!bus.d_busywait) found = 1'b1;
            end
            e = exp_q.pop_front();
            $display("txn D write addr=%h latency=%0d data=%h", e.addr, n, e.data);
            n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL wr_latency: got %0d want 6", n); end
            n_cmp++; if (strobes !== 5) begin n_bad++; $display("FAIL wr_strobe_cycles: got %0d want 5", strobes); end
            n_cmp++; if (wmem[e.addr] !== e.data) begin n_bad++; $display("FAIL wr_mem: got %h want %h", wmem[e.addr], e.data); end
            n_cmp++; if (bus.d_readdata !== rd_before) begin n_bad++; $display("FAIL wr_readdata_kept: got %h want %h", bus.d_readdata, rd_before); end
            n_cmp++; if (bus.m_write !== 1'b0) begin n_bad++; $display("FAIL wr_rel_m_write: got %b want 0", bus.m_write); end
            bus.d_write = 1'b0;
            bus.d_read  = 1'b0;
            rr_d = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic test_tie();
        txn_t ed, ei, e; int cyc; bit got_d, first_d;
        logic [BLOCK_W-1:0] rd;
`ifdef ROUND_ROBIN_EN
        first_d = rr_d;
`else
        first_d = 1'b1;
`endif
        mem_lat = 5;
        ed.is_d = 1'b1; ed.is_wr = 1'b0; ed.addr = 6'h0A; ed.data = pat(10);
        ei.is_d = 1'b0; ei.is_wr = 1'b0; ei.addr = 6'h14; ei.data = pat(20);
        if (first_d) begin exp_q.push_back(ed); exp_q.push_back(ei); end
        else begin exp_q.push_back(ei); exp_q.push_back(ed); end
        bus.d_address = 6'h0A;
        bus.i_address = 6'h14;
        bus.d_read    = 1'b1;
        bus.i_read    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_release(cyc, got_d);
            e  = exp_q.pop_front();
            rd = e.is_d ? bus.d_readdata : bus.i_readdata;
            $display("txn %s read addr=%h latency=%0d data=%h", got_d ? "D" : "I", e.addr, cyc, rd);
            n_cmp++; if (got_d !== e.is_d) begin n_bad++; $display("FAIL tie_grant%0d: got d=%0d want d=%0d", k, got_d, e.is_d); end
            n_cmp++; if (cyc !== ((k == 0) ? 6 : 7)) begin n_bad++; $display("FAIL tie_latency%0d: got %0d want %0d", k, cyc, (k == 0) ? 6 : 7); end
            n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL tie_data%0d: got %h want %h", k, rd, e.data); end
            if (k == 0) begin
                n_cmp++; if ((e.is_d ? bus.i_busywait : bus.d_busywait) !== 1'b1) begin n_bad++; $display("FAIL tie_loser_stalled: got 0 want 1"); end
            end
            rr_d = !e.is_d;
            if (e.is_d) bus.d_read = 1'b0;
            else bus.i_read = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic test_first_cycle();
        txn_t e; int cyc; bit got_d;
        mem_lat = 1;  // memory never raises busywait
        e.is_d = 1'b1; e.is_wr = 1'b0; e.addr = 6'h07; e.data = pat(7);
        exp_q.push_back(e);
        bus.d_address = 6'h07;
        bus.d_read    = 1'b1;
        wait_release(cyc, got_d);
        e = exp_q.pop_front();
        $display("txn D read addr=%h latency=%0d data=%h", e.addr, cyc, bus.d_readdata);
        n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL fc_latency: got %0d want 3", cyc); end
        n_cmp++; if (bus.d_readdata !== e.data) begin n_bad++; $display("FAIL fc_data: got %h want %h", bus.d_readdata, e.data); end
        bus.d_read = 1'b0;
        rr_d = 1'b0;
        mem_lat = 5;
        @(negedge CLK);
    endtask

    task automatic test_withdraw();
        txn_t e; int n, cyc; bit found, got_d;
        mem_lat = 5;
        bus.d_address = 6'h21;
        bus.d_read    = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++; if (bus.m_read !== 1'b1) begin n_bad++; $display("FAIL wd_m_read_acc: got %b want 1", bus.m_read); end
        bus.d_read = 1'b0;
        n = 2; found = 1'b0;
        while (!found && n < 100) begin
            @(negedge CLK);
            n++;
            if (!bus.m_read) found = 1'b1;
        end
        $display("txn D read (withdrawn) addr=21 completed at cycle %0d", n);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL wd_complete_cycle: got %0d want 6", n); end
        n_cmp++; if (bus.m_write !== 1'b0) begin n_bad++; $display("FAIL wd_rel_m_write: got %b want 0", bus.m_write); end
        n_cmp++; if (bus.d_busywait !== 1'b0) begin n_bad++; $display("FAIL wd_d_busywait: got %b want 0", bus.d_busywait); end
        rr_d = 1'b0;
        @(negedge CLK);
        e.is_d = 1'b0; e.is_wr = 1'b0; e.addr = 6'h06; e.data = pat(6);
        exp_q.push_back(e);
        bus.i_address = 6'h06;
        bus.i_read    = 1'b1;
        wait_release(cyc, got_d);
        e = exp_q.pop_front();
        $display("txn I read addr=%h latency=%0d data=%h", e.addr, cyc, bus.i_readdata);
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL wd_next_latency: got %0d want 6", cyc); end
        n_cmp++; if (bus.i_readdata !== e.data) begin n_bad++; $display("FAIL wd_next_data: got %h want %h", bus.i_readdata, e.data); end
        bus.i_read = 1'b0;
        rr_d = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        txn_t e; int cyc; bit got_d;
        mem_lat = 5;
        e.is_d = 1'b1; e.is_wr = 1'b0; e.addr = 6'h09; e.data = pat(9);
        exp_q.push_back(e);
        bus.d_address = 6'h09;
        bus.d_read    = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++; if (bus.m_read !== 1'b1) begin n_bad++; $display("FAIL rm_pre_m_read: got %b want 1", bus.m_read); end
        RESET = 1'b0;
        @(negedge CLK);
        n_cmp++; if ({bus.m_read, bus.m_write} !== 2'b00) begin n_bad++; $display("FAIL rm_strobes: got %b want 00", {bus.m_read, bus.m_write}); end
        n_cmp++; if (bus.d_readdata !== '0) begin n_bad++; $display("FAIL rm_d_readdata: got %h want 0", bus.d_readdata); end
        n_cmp++; if (bus.i_readdata !== '0) begin n_bad++; $display("FAIL rm_i_readdata: got %h want 0", bus.i_readdata); end
        n_cmp++; if (bus.m_address !== '0) begin n_bad++; $display("FAIL rm_m_address: got %h want 0", bus.m_address); end
        @(negedge CLK);
        RESET = 1'b1;
        rr_d  = 1'b1;
        wait_release(cyc, got_d);
        e = exp_q.pop_front();
        $display("txn D read addr=%h latency=%0d data=%h (after reset)", e.addr, cyc, bus.d_readdata);
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL rm_latency: got %0d want 6", cyc); end
        n_cmp++; if (bus.d_readdata !== e.data) begin n_bad++; $display("FAIL rm_data: got %h want %h", bus.d_readdata, e.data); end
        bus.d_read = 1'b0;
        rr_d = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back_ties();
        txn_t e; int cyc; bit got_d; bit [2:0] order;
        logic [BLOCK_W-1:0] rd;
`ifdef ROUND_ROBIN_EN
        order = 3'b101;  // D, I, D
`else
        order = 3'b111;  // dcache keeps winning
`endif
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        rr_d  = 1'b1;
        mem_lat = 5;
        for (int k = 0; k < 3; k++) begin
            e.is_d  = order[k];
            e.is_wr = 1'b0;
            e.addr  = order[k] ? 6'h30 : 6'h31;
            e.data  = order[k] ? pat(48) : pat(49);
            exp_q.push_back(e);
        end
        bus.d_address = 6'h30;
        bus.i_address = 6'h31;
        bus.d_read    = 1'b1;
        bus.i_read    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_release(cyc, got_d);
            e  = exp_q.pop_front();
            rd = e.is_d ? bus.d_readdata : bus.i_readdata;
            $display("txn %s read addr=%h latency=%0d data=%h (tie %0d)", got_d ? "D" : "I", e.addr, cyc, rd, k);
            n_cmp++; if (got_d !== e.is_d) begin n_bad++; $display("FAIL b2b_grant%0d: got d=%0d want d=%0d", k, got_d, e.is_d); end
            n_cmp++; if (cyc !== ((k == 0) ? 6 : 7)) begin n_bad++; $display("FAIL b2b_latency%0d: got %0d want %0d", k, cyc, (k == 0) ? 6 : 7); end
            n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", k, rd, e.data); end
            rr_d = !e.is_d;
        end
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_tie();
        test_first_cycle();
        test_withdraw();
        test_reset_mid();
        test_back_to_back_ties();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
